// File: rtl/fifo_rd_burst_scheduler.sv
// Read-domain controller for the async FIFO. It tracks the read pointer, computes fill level, and drains the FIFO as bounded bursts.
// Optional statistics counters are built when FIFO_BURST_STATS_EN is defined.
module fifo_rd_burst_scheduler #(
  parameter int ADDRSIZE  = 4,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                rd_clk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic                flush,
  input  logic                out_ready,
  output logic                out_valid,
  output logic                burst_last,
  output logic [ADDRSIZE-1:0] rd_addr,
  output logic                rd_en,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic [15:0]         stat_bursts,
  output logic [15:0]         stat_timeouts
);
  localparam int PW = ADDRSIZE + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW-1:0] BURST_N = PW'(BURST_LEN);
  localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_BURST} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] rbin_q, rbin_d, rptr_q, rptr_d, beats_q, beats_d;
  logic [PW-1:0] wbin;
  logic [TW-1:0] timer_q, timer_d;
  logic          start_burst, start_forced;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin = '0;
    for (int i = 0; i < PW; i++) wbin[i] = ^(rq2_wptr >> i);
  end

  assign rlevel     = wbin - rbin_q;
  assign rempty     = (rq2_wptr == rptr_q);
  assign out_valid  = (state_q == S_BURST);
  assign burst_last = out_valid && (beats_q == PW'(1));
  assign rd_en      = out_valid && out_ready;
  assign rd_addr    = rbin_q[ADDRSIZE-1:0];
  assign rptr       = rptr_q;

  always_comb begin
    state_d      = state_q;
    beats_d      = beats_q;
    timer_d      = timer_q;
    start_burst  = 1'b0;
    start_forced = 1'b0;
    rbin_d       = rd_en ? rbin_q + PW'(1) : rbin_q;
    rptr_d       = rbin_d ^ (rbin_d >> 1);
    case (state_q)
      S_IDLE: begin
        if (rlevel >= BURST_N) begin
          state_d     = S_BURST;
          beats_d     = BURST_N;
          start_burst = 1'b1;
        end else if (rlevel != '0) begin
          if (flush) begin
            state_d      = S_BURST;
            beats_d      = rlevel;
            start_burst  = 1'b1;
            start_forced = 1'b1;
          end else begin
            state_d = S_ACCUM;
            timer_d = '0;
          end
        end
      end
      S_ACCUM: begin
        timer_d = timer_q + TW'(1);
        if (rlevel >= BURST_N) begin
          state_d     = S_BURST;
          beats_d     = BURST_N;
          start_burst = 1'b1;
        end else if (timer_q == TMAX || flush) begin
          // Level only grows while waiting, so it is nonzero here.
          state_d      = S_BURST;
          beats_d      = rlevel;
          start_burst  = 1'b1;
          start_forced = 1'b1;
        end
      end
      S_BURST: begin
        if (rd_en) begin
          beats_d = beats_q - PW'(1);
          if (beats_q == PW'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (!rrst_n) begin
      state_q <= S_IDLE;
      rbin_q  <= '0;
      rptr_q  <= '0;
      beats_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      rbin_q  <= rbin_d;
      rptr_q  <= rptr_d;
      beats_q <= beats_d;
      timer_q <= timer_d;
    end
  end

`ifdef FIFO_BURST_STATS_EN
  logic [15:0] stat_bursts_q, stat_bursts_d, stat_timeouts_q, stat_timeouts_d;

  always_comb begin
    stat_bursts_d   = stat_bursts_q;
    stat_timeouts_d = stat_timeouts_q;
    if (start_burst && stat_bursts_q != 16'hFFFF) stat_bursts_d = stat_bursts_q + 16'd1;
    if (start_forced && stat_timeouts_q != 16'hFFFF) stat_timeouts_d = stat_timeouts_q + 16'd1;
  end

  always_ff @(posedge rd_clk) begin
    if (!rrst_n) begin
      stat_bursts_q   <= '0;
      stat_timeouts_q <= '0;
    end else begin
      stat_bursts_q   <= stat_bursts_d;
      stat_timeouts_q <= stat_timeouts_d;
    end
  end

  assign stat_bursts   = stat_bursts_q;
  assign stat_timeouts = stat_timeouts_q;
`else
  logic unused_stats;
  assign unused_stats  = start_burst ^ start_forced;
  assign stat_bursts   = '0;
  assign stat_timeouts = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_burst_scheduler.sv
// Bench for fifo_rd_burst_scheduler: a beat-counting reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_fifo_rd_burst_scheduler;
  localparam int BL = 4;
  localparam int TO = 16;
`ifdef FIFO_BURST_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       rd_clk = 1'b0;
  logic       rrst_n = 1'b0;
  logic [4:0] rq2_wptr = 5'd0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b1;
  logic       out_valid, burst_last, rd_en, rempty;
  logic [3:0] rd_addr;
  logic [4:0] rptr, rlevel;
  logic [15:0] stat_bursts, stat_timeouts;

  fifo_rd_burst_scheduler dut (
    .rd_clk(rd_clk), .rrst_n(rrst_n), .rq2_wptr(rq2_wptr), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid), .burst_last(burst_last),
    .rd_addr(rd_addr), .rd_en(rd_en), .rptr(rptr), .rempty(rempty),
    .rlevel(rlevel), .stat_bursts(stat_bursts), .stat_timeouts(stat_timeouts)
  );

  always #5 rd_clk = ~rd_clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pops done, beats left in the current burst, age of a partial fill.
  int m_rd = 0, m_left = 0, m_age = -1, m_nb = 0, m_nt = 0, lvl = 0, lvl_c = 0;
  bit m_init = 1'b0;

  function automatic int g2b(input logic [4:0] g);
    for (int b = 0; b < 32; b++) if (5'(b ^ (b >> 1)) == g) return b;
    return 0;
  endfunction

  function automatic logic [4:0] gray(input int b);
    return 5'(b ^ (b >> 1));
  endfunction

  function automatic int m_level();
    return (g2b(rq2_wptr) - m_rd + 32) % 32;
  endfunction

  always @(posedge rd_clk) begin
    if (!rrst_n) begin
      m_rd = 0; m_left = 0; m_age = -1; m_nb = 0; m_nt = 0; m_init = 1'b1;
    end else if (m_init) begin
      lvl = m_level();
      if (m_left > 0) begin
        if (out_ready) begin m_rd = (m_rd + 1) % 32; m_left--; end
      end else if (lvl >= BL) begin
        m_left = BL; m_age = -1; m_nb++;
      end else if (lvl > 0 && (flush || m_age == TO - 1)) begin
        m_left = lvl; m_age = -1; m_nb++; m_nt++;
      end else if (lvl > 0) begin
        m_age++;
      end
    end
  end

  always @(negedge rd_clk) begin
    #3;
    if (m_init) begin
      lvl_c = m_level();
      chk("out_valid", out_valid, m_left > 0);
      chk("burst_last", burst_last, m_left == 1);
      chk("rd_addr", rd_addr, m_rd % 16);
      chk("rd_en", rd_en, (m_left > 0) && out_ready);
      chk("rptr", rptr, gray(m_rd));
      chk("rlevel", rlevel, lvl_c);
      chk("rempty", rempty, lvl_c == 0);
      chk("stat_bursts", stat_bursts, STATS ? m_nb : 0);
      chk("stat_timeouts", stat_timeouts, STATS ? m_nt : 0);
    end
  end

  // Leaves the caller at the exact negedge where reset is released.
  task automatic reset_dut();
    @(negedge rd_clk);
    rrst_n = 1'b0; rq2_wptr = 5'd0; flush = 1'b0; out_ready = 1'b1;
    @(negedge rd_clk);
    rrst_n = 1'b1;
  endtask

  task automatic wait_drained(input int bound);
    int n = 0;
    #3;
    while (n < bound && !(rempty && !out_valid)) begin
      @(negedge rd_clk); #3; n++;
    end
    chk("drain_done", rempty && !out_valid, 1);
  endtask

  int n;
  int wrap_addr [4] = '{14, 15, 0, 1};

  initial begin
    // Reset state
    @(negedge rd_clk); #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rptr", rptr, 5'b00000);
    chk("rst_rlevel", rlevel, 0);
    chk("rst_rempty", rempty, 1);
    chk("rst_stats", {stat_bursts, stat_timeouts}, 0);

    // Full burst of 4
    reset_dut();
    rq2_wptr = 5'b00110;
    for (int k = 0; k < 4; k++) begin
      @(negedge rd_clk); #3;
      chk("b4_valid", out_valid, 1);
      chk("b4_addr", rd_addr, k);
      chk("b4_last", burst_last, k == 3);
    end
    @(negedge rd_clk); #3;
    chk("b4_end_valid", out_valid, 0);
    chk("b4_end_rptr", rptr, 5'b00110);
    chk("b4_end_empty", rempty, 1);
    chk("b4_stat_bursts", stat_bursts, STATS ? 1 : 0);

    // Flush with empty FIFO does nothing
    @(negedge rd_clk); flush = 1'b1;
    @(negedge rd_clk); flush = 1'b0; #3;
    chk("flush_empty_valid", out_valid, 0);

    // Partial fill forced out by timeout
    reset_dut();
    rq2_wptr = 5'b00011;
    n = 0;
    do begin @(negedge rd_clk); #3; n++; end while (!out_valid && n < 40);
    chk("timeout_latency", n, 17);
    chk("to_addr0", rd_addr, 0);
    chk("to_last0", burst_last, 0);
    @(negedge rd_clk); #3;
    chk("to_addr1", rd_addr, 1);
    chk("to_last1", burst_last, 1);
    @(negedge rd_clk); #3;
    chk("to_end_valid", out_valid, 0);
    chk("to_end_rptr", rptr, 5'b00011);
    chk("to_stat_timeouts", stat_timeouts, STATS ? 1 : 0);

    // Partial fill forced out by flush
    reset_dut();
    rq2_wptr = 5'b00011;
    @(negedge rd_clk); @(negedge rd_clk); @(negedge rd_clk);
    #3; chk("fl_pre_valid", out_valid, 0);
    flush = 1'b1;
    @(negedge rd_clk); flush = 1'b0; #3;
    chk("fl_valid", out_valid, 1);
    chk("fl_addr", rd_addr, 0);
    wait_drained(20);
    chk("fl_stat_timeouts", stat_timeouts, STATS ? 1 : 0);

    // Backpressure after the first beat
    reset_dut();
    rq2_wptr = 5'b00110;
    @(negedge rd_clk); #3;
    chk("bp_addr0", rd_addr, 0);
    @(negedge rd_clk);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("bp_hold_addr", rd_addr, 1);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_rptr", rptr, 5'b00001);
      @(negedge rd_clk);
    end
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      #3;
      chk("bp_resume_addr", rd_addr, k);
      @(negedge rd_clk);
    end
    #3;
    chk("bp_end_rptr", rptr, 5'b00110);

    // Reset mid-burst abandons it
    reset_dut();
    rq2_wptr = 5'b00110;
    @(negedge rd_clk); @(negedge rd_clk);
    rrst_n = 1'b0;
    @(negedge rd_clk);
    rrst_n = 1'b1; #3;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_rptr", rptr, 5'b00000);
    wait_drained(40);

    // Pointer wrap through address 15 -> 0
    reset_dut();
    rq2_wptr = 5'b01001;
    wait_drained(300);
    chk("wrap_pre_rptr", rptr, 5'b01001);
    @(negedge rd_clk);
    rq2_wptr = 5'b11011;
    for (int k = 0; k < 4; k++) begin
      @(negedge rd_clk); #3;
      chk("wrap_addr", rd_addr, wrap_addr[k]);
    end
    @(negedge rd_clk); #3;
    chk("wrap_end_rptr", rptr, 5'b11011);
    chk("wrap_end_empty", rempty, 1);

    // Completely full FIFO
    reset_dut();
    rq2_wptr = 5'b11000;
    #3;
    chk("full_level", rlevel, 16);
    chk("full_empty", rempty, 0);
    wait_drained(300);
    chk("full_stat_bursts", stat_bursts, STATS ? 4 : 0);
    chk("full_end_rptr", rptr, 5'b11000);

    @(negedge rd_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/fifo_rd_burst_scheduler.md
Name: fifo_rd_burst_scheduler

Overview:
Read-domain controller for the async FIFO. It consumes the 2-flop-synchronized Gray write pointer, keeps the read pointer in binary and Gray, and computes fill level and empty. It schedules FIFO drains as bounded bursts toward the downstream consumer (AXI-to-I2C byte engine) over a valid/ready handshake. It drives the FIFO RAM read address and enable, and feeds the Gray read pointer back to the write-domain synchronizer.

Parameters:
ADDRSIZE, 4, FIFO address width; depth = 2**ADDRSIZE, pointers ADDRSIZE+1 bits
BURST_LEN, 4, max beats per burst (1..2**ADDRSIZE)
TIMEOUT, 16, cycles a partial fill (0 < level < BURST_LEN) waits before a short burst is forced (>=1)

Ports:
rd_clk  in  1  read-domain clock
rrst_n  in  1  synchronous active-low reset
rq2_wptr  in  ADDRSIZE+1  synchronized Gray write pointer
flush  in  1  pulse: force burst of current level (capped at BURST_LEN)
out_ready  in  1  consumer accepts beat
out_valid  out  1  beat available (RAM data at rd_addr valid)
burst_last  out  1  final beat of current burst
rd_addr  out  ADDRSIZE  RAM read address = rbin[ADDRSIZE-1:0]
rd_en  out  1  pop strobe = out_valid && out_ready
rptr  out  ADDRSIZE+1  Gray read pointer, registered
rempty  out  1  rq2_wptr == rptr
rlevel  out  ADDRSIZE+1  wbin - rbin, modulo 2**(ADDRSIZE+1), range 0..2**ADDRSIZE
stat_bursts  out  16  bursts issued (see Optional Feature)
stat_timeouts  out  16  bursts forced by timeout/flush

Behaviour:
- Clock/reset: one clock rd_clk; reset rrst_n is synchronous, active-low. Sampled only on posedge rd_clk.
- Reset: rbin=0, rptr=0, state=IDLE, timer=0, beats=0, stats=0. Hence out_valid=0, burst_last=0, rd_en=0, rd_addr=0, rptr=0. rlevel/rempty follow rq2_wptr; with rq2_wptr=0, rlevel=0 and rempty=1.
- wbin = Gray-to-binary(rq2_wptr), combinational. rlevel and rempty are combinational from registered rbin/rptr and the input.
- On each rd_en: rbin <= rbin+1 (wraps at 2**(ADDRSIZE+1)), rptr <= bin2gray(rbin+1). rptr changes by exactly one bit per pop.
- FSM (Moore for out_valid):
  - IDLE: rlevel>=BURST_LEN -> BURST, beats=BURST_LEN. Else flush && rlevel>0 -> BURST, beats=rlevel. Else rlevel>0 -> ACCUM, timer=0. Else stay.
  - ACCUM: timer++ each cycle. rlevel>=BURST_LEN -> BURST, beats=BURST_LEN. Else (timer==TIMEOUT-1 or flush) -> BURST, beats=rlevel, timeout flag set.
  - BURST: out_valid=1. burst_last=(beats==1). Each rd_en decrements beats. Final rd_en -> IDLE.
- Level is sampled in cycle t; BURST and out_valid begin at t+1.
- Invariant: beats <= rlevel throughout BURST, because the write side only increases wbin. out_valid therefore never asserts while rempty=1.
- out_ready low: out_valid, rd_addr, burst_last held stable; no pointer change. out_valid never drops mid-burst.
- Full (rlevel=2**ADDRSIZE) is legal; it drains normally.
- flush in BURST is ignored. flush with rlevel=0 is ignored.
- Reset mid-burst returns to reset state next edge; partially issued bursts are abandoned.

Optional Feature:
Macro FIFO_BURST_STATS_EN.
- Defined: stat_bursts increments on each IDLE/ACCUM->BURST transition. stat_timeouts increments on those caused by timeout or flush. Both saturate at 16'hFFFF and are cleared by reset.
- Undefined: counters not built; both ports driven constant 0.

Test Plan:
- Reset with rq2_wptr=0 -> out_valid=0, rd_en=0, rptr=0, rlevel=0, rempty=1, stats=0.
- rq2_wptr=5'b00110 (bin 4), out_ready=1 -> out_valid next cycle; rd_addr 0,1,2,3 over 4 cycles; burst_last on addr 3; final rptr=5'b00110, rempty=1, stat_bursts=1.
- rq2_wptr=5'b00011 (bin 2) held -> ACCUM 16 cycles, then 2-beat burst at addr 0,1; stat_timeouts=1. Repeat with flush after 3 cycles -> burst starts 1 cycle later.
- Burst of 4 with out_ready low for 5 cycles after beat 1 -> rd_addr=1 and out_valid held, rptr unchanged, then resumes 1,2,3.
- Wrap: pointers at bin 14 (Gray 5'b01001), rq2_wptr to bin 18 (Gray 5'b11011) -> addr 14,15,0,1; rptr ends 5'b11011.
- Full: rq2_wptr=Gray(16)=5'b11000 from 0 -> rlevel=16; four 4-beat bursts; stat_bursts=4; ends rempty=1.
